// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register file and its clients: widths, the zero register, and the writeback entry.
package regfile_wb_ctrl_pkg;

    localparam int unsigned AW       = 5;
    localparam int unsigned DW       = 32;
    localparam int unsigned WB_DEPTH = 4;

    localparam logic [AW-1:0] REG_ZERO = AW'(0);

    typedef struct packed {
        logic [AW-1:0] wr;
        logic [DW-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request, register-file write port and forwarding lookup signals of the writeback controller.
interface regfile_wb_ctrl_if
    import regfile_wb_ctrl_pkg::*;
();

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_wr;
    logic [DW-1:0] alu_d;

    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_wr;
    logic [DW-1:0] mem_d;

    logic [AW-1:0] Wr;
    logic [DW-1:0] D;
    logic          We;

    logic [AW-1:0] Ra;
    logic [AW-1:0] Rb;
    logic          fwd_hit_a;
    logic [DW-1:0] fwd_d_a;
    logic          fwd_hit_b;
    logic [DW-1:0] fwd_d_b;

    logic          busy;

    modport slave (
        input  alu_valid, alu_wr, alu_d,
        input  mem_valid, mem_wr, mem_d,
        input  Ra, Rb,
        output alu_ready, mem_ready,
        output Wr, D, We,
        output fwd_hit_a, fwd_d_a, fwd_hit_b, fwd_d_b,
        output busy
    );

    modport master (
        output alu_valid, alu_wr, alu_d,
        output mem_valid, mem_wr, mem_d,
        output Ra, Rb,
        input  alu_ready, mem_ready,
        input  Wr, D, We,
        input  fwd_hit_a, fwd_d_a, fwd_hit_b, fwd_d_b,
        input  busy
    );

endinterface

// File: rtl/regfile_wb_ctrl_fwd_lookup.sv
// Forwarding lookup: finds the youngest valid pending write to a register.
// Entries arrive age-ordered, index 0 oldest, index DEPTH-1 youngest.
module wb_fwd_lookup
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic      [DEPTH-1:0] valid,
    input  logic      [AW-1:0]    ra,
    output logic                  hit,
    output logic      [DW-1:0]    d
);

    // Scan youngest first; the first match wins. The zero register never forwards.
    always_comb begin
        hit = 1'b0;
        d   = '0;
        if (ra != REG_ZERO) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!hit && valid[i] && (entries[i].wr == ra)) begin
                    hit = 1'b1;
                    d   = entries[i].d;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/load requests into an in-order buffer,
// drains one write per cycle, and forwards pending data to two readers.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic              Clk,
    input  logic              Rst,
    regfile_wb_ctrl_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    wb_entry_t     buf_q [DEPTH];

    logic      room;
    logic      accept_alu;
    logic      accept_mem;
    logic      enq;
    logic      deq;
    wb_entry_t enq_entry;

    wb_entry_t [DEPTH-1:0] age_entry;
    logic      [DEPTH-1:0] age_valid;

    // Readiness looks only at the registered count; a same-cycle pop never frees a slot.
    assign room          = (count_q < CW'(DEPTH));
    assign bus.alu_ready = ~Rst & room;
    assign bus.mem_ready = ~Rst & room & ~bus.alu_valid;

    assign accept_alu = bus.alu_valid & bus.alu_ready;
    assign accept_mem = bus.mem_valid & bus.mem_ready;

    always_comb begin
        enq_entry = '0;
        if (accept_alu) begin
            enq_entry.wr = bus.alu_wr;
            enq_entry.d  = bus.alu_d;
        end else if (accept_mem) begin
            enq_entry.wr = bus.mem_wr;
            enq_entry.d  = bus.mem_d;
        end
    end

    // Writes to the zero register complete the handshake but are dropped here.
    assign enq = (accept_alu | accept_mem) & (enq_entry.wr != REG_ZERO);

    // The register file always takes the head write, so the head pops whenever the buffer is non-empty.
    assign deq      = (count_q != '0) & ~Rst;
    assign bus.busy = (count_q != '0);
    assign bus.We   = deq;
    assign bus.Wr   = bus.busy ? buf_q[rd_ptr_q].wr : REG_ZERO;
    assign bus.D    = bus.busy ? buf_q[rd_ptr_q].d  : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; validity is carried by count and the pointers.
    always_ff @(posedge Clk) begin
        if (enq) begin
            buf_q[wr_ptr_q] <= enq_entry;
        end
    end

    // Present the buffer oldest-to-youngest so the lookup can prioritise by index.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entry[i] = buf_q[rd_ptr_q + PW'(i)];
            age_valid[i] = (CW'(i) < count_q);
        end
    end

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
        .entries (age_entry),
        .valid   (age_valid),
        .ra      (bus.Ra),
        .hit     (bus.fwd_hit_a),
        .d       (bus.fwd_d_a)
    );

    wb_fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
        .entries (age_entry),
        .valid   (age_valid),
        .ra      (bus.Rb),
        .hit     (bus.fwd_hit_b),
        .d       (bus.fwd_d_b)
    );

endmodule
